// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter among N_REQ sources.
// Define UART_ARB_TIMEOUT_EN to force release of a lock stalled for TIMEOUT_CYCLES.
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   last,
  input  logic [8*N_REQ-1:0] data,
  output logic [N_REQ-1:0]   ack,
  output logic [2:0]         owner,
  output logic               locked,
  output logic [7:0]         tx_data,
  output logic               tx_send,
  input  logic               tx_busy,
  output logic               timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WHI   = 2'd2;
  localparam logic [1:0] S_WLO   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [2:0]       owner_q, owner_d;
  logic [2:0]       rr_q, rr_d;
  logic             locked_q, locked_d;
  logic [7:0]       txd_q, txd_d;
  logic             send_q, send_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             last_q, last_d;
  logic             hi_q, hi_d;
  logic             tmo_q, tmo_d;
  logic             tmo_hit;

  logic [2:0] win;
  logic       found;
  logic [7:0] own_data;
  logic       own_req;
  logic       own_last;

  // Search starts just after the last releasing owner.
  always_comb begin
    int idx;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = 3'(idx);
      end
    end
  end

  always_comb begin
    own_data = '0;
    own_req  = 1'b0;
    own_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == 3'(i)) begin
        own_data = data[8*i +: 8];
        own_req  = req[i];
        own_last = last[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    locked_d = locked_q;
    txd_d    = txd_q;
    send_d   = 1'b0;
    ack_d    = '0;
    last_d   = last_q;
    hi_d     = 1'b0;
    tmo_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          owner_d  = win;
          locked_d = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (own_req && !tx_busy) begin
          txd_d   = own_data;
          send_d  = 1'b1;
          ack_d   = N_REQ'(1) << owner_q;
          last_d  = own_last;
          state_d = S_WHI;
        end
      end
      S_WHI: begin
        hi_d = 1'b1;
        if (tx_busy || hi_q) state_d = S_WLO;
      end
      S_WLO: begin
        if (!tx_busy) begin
          if (last_q) begin
            rr_d     = owner_q;
            locked_d = 1'b0;
            state_d  = S_IDLE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
    endcase
    if (tmo_hit && state_d == state_q) begin
      tmo_d    = 1'b1;
      rr_d     = owner_q;
      locked_d = 1'b0;
      state_d  = S_IDLE;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  assign tmo_hit = (state_q == S_ISSUE || state_q == S_WLO) &&
                   cnt_q == 16'(TIMEOUT_CYCLES - 1);

  always_comb begin
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= S_IDLE;
      owner_q  <= 3'(N_REQ - 1);
      rr_q     <= 3'(N_REQ - 1);
      locked_q <= 1'b0;
      txd_q    <= '0;
      send_q   <= 1'b0;
      ack_q    <= '0;
      last_q   <= 1'b0;
      hi_q     <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      locked_q <= locked_d;
      txd_q    <= txd_d;
      send_q   <= send_d;
      ack_q    <= ack_d;
      last_q   <= last_d;
      hi_q     <= hi_d;
      tmo_q    <= tmo_d;
    end
  end

  assign ack     = ack_q;
  assign owner   = owner_q;
  assign locked  = locked_q;
  assign tx_data = txd_q;
  assign tx_send = send_q;
  assign timeout = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: per-requester packet queues and
// a round-robin packet-order model, plus directed latency/stall/reset cases.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TMO = 64;

  logic           clk = 1'b0;
  logic           nRst;
  logic [N-1:0]   req;
  logic [N-1:0]   last;
  logic [8*N-1:0] data;
  logic [N-1:0]   ack;
  logic [2:0]     owner;
  logic           locked;
  logic [7:0]     tx_data;
  logic           tx_send;
  logic           tx_busy;
  logic           timeout;

  int errors = 0;
  int checks = 0;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk     (clk),
    .nRst    (nRst),
    .req     (req),
    .last    (last),
    .data    (data),
    .ack     (ack),
    .owner   (owner),
    .locked  (locked),
    .tx_data (tx_data),
    .tx_send (tx_send),
    .tx_busy (tx_busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // UART model: busy for busy_len cycles after each start pulse
  int busy_len = 10;
  int busy_left;
  always @(posedge clk or negedge nRst) begin
    if (!nRst)              busy_left <= 0;
    else if (tx_send)       busy_left <= busy_len;
    else if (busy_left > 0) busy_left <= busy_left - 1;
  end
  assign tx_busy = (busy_left != 0);

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_rst(string pfx);
    chk({pfx, "_ack"}, 32'(ack), 0);
    chk({pfx, "_owner"}, 32'(owner), N - 1);
    chk({pfx, "_locked"}, 32'(locked), 0);
    chk({pfx, "_txdata"}, 32'(tx_data), 0);
    chk({pfx, "_send"}, 32'(tx_send), 0);
    chk({pfx, "_tmo"}, 32'(timeout), 0);
  endtask

  // Reference model state
  logic [7:0] qd [N][$];
  bit         ql [N][$];
  int         pause [N];
  int         m_rr;
  bit         in_pkt;
  int         cur;

  task automatic model_init();
    for (int i = 0; i < N; i++) begin
      qd[i].delete();
      ql[i].delete();
      pause[i] = 0;
    end
    m_rr   = N - 1;
    in_pkt = 0;
    cur    = 0;
  endtask

  task automatic do_reset();
    nRst = 1'b0;
    req  = '0;
    last = '0;
    data = '0;
    @(negedge clk);
    chk_rst("rst");
    @(negedge clk);
    nRst = 1'b1;
    model_init();
  endtask

  function automatic int remaining();
    int s = 0;
    for (int i = 0; i < N; i++) s += qd[i].size();
    return s;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (qd[i].size() > 0 && pause[i] == 0) begin
        req[i]        = 1'b1;
        data[8*i +: 8] = qd[i][0];
        last[i]       = ql[i][0];
      end else begin
        req[i] = 1'b0;
      end
    end
  endtask

  // Called once per cycle at the falling edge
  task automatic step();
    int  e;
    bit  lb;
    for (int i = 0; i < N; i++) if (pause[i] > 0) pause[i]--;
    if (tx_send) begin
      e = -1;
      if (in_pkt) e = cur;
      else
        for (int k = 1; k <= N; k++) begin
          automatic int j = (m_rr + k) % N;
          if (e < 0 && qd[j].size() > 0) e = j;
        end
      if (e < 0) begin
        chk("spurious_send", 32'(tx_send), 0);
      end else begin
        chk("src_ack", 32'(ack), 32'(1 << e));
        chk("owner", 32'(owner), e);
        chk("data", 32'(tx_data), 32'(qd[e][0]));
        lb = ql[e][0];
        void'(qd[e].pop_front());
        void'(ql[e].pop_front());
        if (lb) begin
          in_pkt = 0;
          m_rr   = e;
        end else begin
          in_pkt = 1;
          cur    = e;
          if ($urandom_range(0, 3) == 0) pause[e] = $urandom_range(1, 50);
        end
      end
    end else begin
      chk("ack_idle", 32'(ack), 0);
    end
    drive();
  endtask

  task automatic push_pkt(int i, int len);
    for (int b = 0; b < len; b++) begin
      qd[i].push_back(8'($urandom_range(0, 255)));
      ql[i].push_back(b == len - 1);
    end
  endtask

  // mode 0 random, 1 all single-byte, 2 long packet on 0 with 2 pending
  task automatic round(int mode, int blen);
    int n;
    busy_len = blen;
    for (int i = 0; i < N; i++) begin
      if (mode == 1) begin
        push_pkt(i, 1);
        push_pkt(i, 1);
      end else if (mode == 0) begin
        for (int p = $urandom_range(0, 3); p > 0; p--)
          push_pkt(i, $urandom_range(1, 6));
      end
    end
    if (mode == 2) begin
      push_pkt(0, 16);
      push_pkt(2, 1);
      push_pkt(2, 3);
    end
    drive();
    n = 0;
    while (remaining() > 0 && n < 20000) begin
      @(negedge clk);
      step();
      n++;
    end
    n = 0;
    while (locked && n < 200) begin
      @(negedge clk);
      step();
      n++;
    end
    chk("drain", 32'(remaining()), 0);
    chk("release", 32'(locked), 0);
  endtask

  int n;
  int sends;
  bit tmo_seen;

  initial begin
    nRst = 1'b0;
    req  = '0;
    last = '0;
    data = '0;
    do_reset();

    // Single-byte packet latency and lock hold
    busy_len   = 10;
    req        = 4'b0001;
    last       = 4'b0001;
    data[7:0]  = 8'hA5;
    @(negedge clk);
    chk("t1_early_send", 32'(tx_send), 0);
    chk("t1_locked", 32'(locked), 1);
    @(negedge clk);
    chk("t1_send", 32'(tx_send), 1);
    chk("t1_ack", 32'(ack), 4'b0001);
    chk("t1_data", 32'(tx_data), 8'hA5);
    req = '0;
    @(negedge clk);
    chk("t1_ack_pulse", 32'(ack), 0);
    chk("t1_send_pulse", 32'(tx_send), 0);
    repeat (6) @(negedge clk);
    chk("t1_hold", 32'(locked), 1);
    n = 0;
    while (locked && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t1_release", 32'(locked), 0);
    chk("t1_owner", 32'(owner), 0);

    // Model-checked traffic
    do_reset();
    round(1, 2);
    round(2, 4);
    round(0, 0);
    for (int r = 0; r < 6; r++) round(0, $urandom_range(0, 8));

    // Owner stalls mid-packet while requester 1 waits
    do_reset();
    busy_len  = 3;
    req       = 4'b0011;
    last      = 4'b0010;
    data      = 32'h0000_5A3C;
    n = 0;
    while (!tx_send && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_first", 32'(ack), 4'b0001);
    req[0] = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    n = 0;
    while (!timeout && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_pulse", 32'(timeout), 1);
    chk("tmo_unlock", 32'(locked), 0);
    @(negedge clk);
    chk("tmo_width", 32'(timeout), 0);
    n = 0;
    while (!tx_send && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_next", 32'(ack), 4'b0010);
`else
    tmo_seen = 0;
    sends    = 0;
    repeat (1000) begin
      @(negedge clk);
      if (timeout) tmo_seen = 1;
      if (tx_send) sends++;
    end
    chk("stall_locked", 32'(locked), 1);
    chk("stall_owner", 32'(owner), 0);
    chk("stall_tmo", 32'(tmo_seen), 0);
    chk("stall_sends", 32'(sends), 0);
`endif

    // Asynchronous reset in the middle of a packet
    do_reset();
    busy_len = 20;
    req      = 4'b0100;
    last     = 4'b0000;
    data     = 32'h0077_0000;
    n = 0;
    while (!tx_send && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_send", 32'(ack), 4'b0100);
    repeat (3) @(negedge clk);
    chk("mid_locked", 32'(locked), 1);
    #2;
    nRst = 1'b0;
    #1;
    chk_rst("mid_rst");
    @(negedge clk);
    nRst = 1'b1;
    req  = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
